// File: rtl/hdmi_packet_pkg.sv
// Purpose : shared constants, types and ECC step function for the HDMI data-island packet serializer.
// Latency : n/a (declarations only).
// Backpressure: n/a.
//
// Contents: BCH ECC polynomial, packet geometry, bit-counter type and the
// single-bit ECC step used by every ECC register.
package hdmi_packet_pkg;

  localparam logic [7:0] ECC_POLY         = 8'h83;
  localparam int         PACKET_BITS      = 32;
  localparam int         HEADER_DATA_BITS = 24;
  localparam int         SUB_DATA_BITS    = 56;
  localparam int         SUBPACKETS       = 4;

  localparam int CNT_W     = $clog2(PACKET_BITS);
  // One header lane plus an even and an odd lane per subpacket.
  localparam int LANE_BITS = 1 + 2 * SUBPACKETS;

  typedef logic [CNT_W-1:0] bit_cnt_t;

  // First bit index that carries ECC instead of payload, per lane type.
  // Subpackets move two payload bits per cycle, hence the halving.
  localparam bit_cnt_t HDR_ECC_START = bit_cnt_t'(HEADER_DATA_BITS);
  localparam bit_cnt_t SUB_ECC_START = bit_cnt_t'(SUB_DATA_BITS / 2);
  localparam bit_cnt_t LAST_BIT      = bit_cnt_t'(PACKET_BITS - 1);

  // One bit of the serial BCH LFSR: shift right, fold in the polynomial when
  // the outgoing bit differs from the incoming data bit.
  function automatic logic [7:0] ecc_step(input logic [7:0] ecc, input logic d);
    return (ecc >> 1) ^ ((ecc[0] ^ d) ? ECC_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/bch_ecc_lfsr.sv
// Purpose : one 8-bit BCH ECC register consuming WIDTH data bits per cycle (LSB first).
// Latency : ecc reflects the bits consumed on the previous edge.
// Backpressure: none; advances only when update is high.
//
// Ports:
//   clk_pixel, reset_n : pixel clock, async active-low reset
//   clear              : start of packet; this edge's update begins from 8'h00
//   update             : consume din this edge (otherwise hold, or zero on clear)
//   din[WIDTH-1:0]     : data bits, din[0] is consumed before din[1]
//   ecc[7:0]           : current ECC value
module bch_ecc_lfsr
  import hdmi_packet_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk_pixel,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             update,
  input  logic [WIDTH-1:0] din,
  output logic [7:0]       ecc
);

  logic [7:0] ecc_next;

  // On the load edge the packet's first data bit(s) are consumed in the same
  // cycle, so the seed must already be zero rather than the stale register.
  always_comb begin
    ecc_next = clear ? 8'h00 : ecc;
    for (int i = 0; i < WIDTH; i++) begin
      ecc_next = ecc_step(ecc_next, din[i]);
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      ecc <= 8'h00;
    end else if (update) begin
      ecc <= ecc_next;
    end else if (clear) begin
      ecc <= 8'h00;
    end
  end

endmodule

// File: rtl/data_island_packet_serializer.sv
// Purpose : serializes one HDMI data-island packet (header + 4 subpackets) with BCH ECC onto 9 lanes.
// Latency : 1 cycle from load to bit 0 on packet_data; 32 output cycles per packet, no gaps.
// Backpressure: none; enable paces the stream, dropping it aborts the packet in flight.
//
// Ports:
//   clk_pixel, reset_n : pixel clock, async active-low reset
//   enable             : high for the whole data-island period
//   header[23:0]       : HB2:HB1:HB0, sampled when load is high
//   sub[3:0][55:0]     : subpackets 0..3, sampled when load is high
//   packet_data[8:0]   : {sub3..0 odd bit, sub3..0 even bit, header bit}
//   packet_valid       : packet_data carries a packet bit
//   packet_last        : bit index 31 of the packet
//   load               : combinational, enable && counter == 0
module data_island_packet_serializer
  import hdmi_packet_pkg::*;
(
  input  logic                                     clk_pixel,
  input  logic                                     reset_n,
  input  logic                                     enable,
  input  logic [HEADER_DATA_BITS-1:0]              header,
  input  logic [SUBPACKETS-1:0][SUB_DATA_BITS-1:0] sub,
  output logic [LANE_BITS-1:0]                     packet_data,
  output logic                                     packet_valid,
  output logic                                     packet_last,
  output logic                                     load
);

  bit_cnt_t                                 cnt;
  logic [HEADER_DATA_BITS-1:0]              hdr_shadow;
  logic [HEADER_DATA_BITS-1:0]              hdr_src;
  logic [SUBPACKETS-1:0][SUB_DATA_BITS-1:0] sub_shadow;
  logic [SUBPACKETS-1:0][SUB_DATA_BITS-1:0] sub_src;
  logic                                     hdr_data_phase;
  logic                                     sub_data_phase;
  logic                                     hdr_bit;
  logic [7:0]                               hdr_ecc;
  logic [7:0]                               sub_ecc [SUBPACKETS];
  logic [SUBPACKETS-1:0]                    sub_even;
  logic [SUBPACKETS-1:0]                    sub_odd;
  logic [LANE_BITS-1:0]                     lane_next;

  assign load = enable && (cnt == '0);

  // Bit 0 is serialized on the same edge that fills the shadow registers, so
  // it must bypass them and come straight from the inputs.
  assign hdr_src = load ? header : hdr_shadow;
  assign sub_src = load ? sub    : sub_shadow;

  assign hdr_data_phase = (cnt < HDR_ECC_START);
  assign sub_data_phase = (cnt < SUB_ECC_START);

  // Out-of-range indices only occur in the ECC phase, where these bits are
  // neither consumed by the LFSRs nor selected onto the lanes.
  assign hdr_bit = hdr_src[cnt];

  bch_ecc_lfsr #(.WIDTH(1)) u_hdr_ecc (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .clear     (load),
    .update    (enable && hdr_data_phase),
    .din       (hdr_bit),
    .ecc       (hdr_ecc)
  );

  for (genvar k = 0; k < SUBPACKETS; k++) begin : g_sub
    assign sub_even[k] = sub_src[k][{cnt, 1'b0}];
    assign sub_odd[k]  = sub_src[k][{cnt, 1'b1}];

    bch_ecc_lfsr #(.WIDTH(2)) u_sub_ecc (
      .clk_pixel (clk_pixel),
      .reset_n   (reset_n),
      .clear     (load),
      .update    (enable && sub_data_phase),
      .din       ({sub_odd[k], sub_even[k]}),
      .ecc       (sub_ecc[k])
    );
  end

  // ECC phases start on multiples of 8 (header) and 4 (subpackets), so the
  // low counter bits directly index the ECC byte.
  always_comb begin
    lane_next    = '0;
    lane_next[0] = hdr_data_phase ? hdr_bit : hdr_ecc[cnt[2:0]];
    for (int k = 0; k < SUBPACKETS; k++) begin
      lane_next[1 + k] = sub_data_phase ? sub_even[k]
                                        : sub_ecc[k][{cnt[1:0], 1'b0}];
      lane_next[1 + SUBPACKETS + k] = sub_data_phase ? sub_odd[k]
                                                     : sub_ecc[k][{cnt[1:0], 1'b1}];
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      cnt          <= '0;
      hdr_shadow   <= '0;
      sub_shadow   <= '0;
      packet_data  <= '0;
      packet_valid <= 1'b0;
      packet_last  <= 1'b0;
    end else if (enable) begin
      cnt          <= cnt + bit_cnt_t'(1);
      packet_data  <= lane_next;
      packet_valid <= 1'b1;
      packet_last  <= (cnt == LAST_BIT);
      if (load) begin
        hdr_shadow <= header;
        sub_shadow <= sub;
      end
    end else begin
      // Abort / idle: drop the partial packet and restart at bit 0.
      cnt          <= '0;
      packet_data  <= '0;
      packet_valid <= 1'b0;
      packet_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_island_packet_serializer.sv
// Purpose : self-checking bench for data_island_packet_serializer against a codeword-level model.
// Latency : checks each output bit one cycle after the edge that produced it.
// Backpressure: n/a.
module tb_data_island_packet_serializer;

  logic             clk_pixel = 1'b0;
  logic             reset_n   = 1'b0;
  logic             enable    = 1'b0;
  logic [23:0]      header    = '0;
  logic [3:0][55:0] sub       = '0;
  logic [8:0]       packet_data;
  logic             packet_valid;
  logic             packet_last;
  logic             load;

  int n_checks = 0;
  int n_fail   = 0;

  data_island_packet_serializer dut (
    .clk_pixel    (clk_pixel),
    .reset_n      (reset_n),
    .enable       (enable),
    .header       (header),
    .sub          (sub),
    .packet_data  (packet_data),
    .packet_valid (packet_valid),
    .packet_last  (packet_last),
    .load         (load)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Serial BCH over the first len bits of a message, LSB first.
  function automatic logic [7:0] bch(input logic [63:0] msg, input int len);
    logic [7:0] e = 8'h00;
    for (int i = 0; i < len; i++) begin
      if (e[0] ^ msg[i]) e = (e >> 1) ^ 8'h83;
      else               e = e >> 1;
    end
    return e;
  endfunction

  function automatic logic [55:0] r56();
    logic [63:0] t = {$urandom(), $urandom()};
    return t[55:0];
  endfunction

  // Drive one packet; bits 0..stop_at-1 are sent and checked (32 = full packet).
  // Inputs are scrambled after bit 0 to show the captured packet is immune.
  task automatic send_packet(input logic [23:0] h, input logic [3:0][55:0] s, input int stop_at);
    logic [31:0] hcw;
    logic [63:0] scw [4];
    logic [8:0]  expd;
    hcw = {bch({40'h0, h}, 24), h};
    for (int k = 0; k < 4; k++) scw[k] = {bch({8'h0, s[k]}, 56), s[k]};
    for (int n = 0; n < stop_at; n++) begin
      enable = 1'b1;
      if (n == 0) begin
        header = h;
        sub    = s;
      end else begin
        header = 24'($urandom());
        for (int k = 0; k < 4; k++) sub[k] = r56();
      end
      #1;
      chk($sformatf("load n=%0d", n), 9'(load), 9'(n == 0));
      @(posedge clk_pixel);
      #1;
      expd[0] = hcw[n];
      for (int k = 0; k < 4; k++) begin
        expd[1 + k] = scw[k][2 * n];
        expd[5 + k] = scw[k][2 * n + 1];
      end
      chk($sformatf("data n=%0d", n), packet_data, expd);
      chk($sformatf("valid n=%0d", n), 9'(packet_valid), 9'd1);
      chk($sformatf("last n=%0d", n), 9'(packet_last), 9'(n == 31));
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      enable = 1'b0;
      #1;
      chk("idle load", 9'(load), 9'd0);
      @(posedge clk_pixel);
      #1;
      chk("idle data", packet_data, 9'd0);
      chk("idle valid", 9'(packet_valid), 9'd0);
      chk("idle last", 9'(packet_last), 9'd0);
    end
  endtask

  initial begin
    logic [3:0][55:0] s;
    logic [3:0][55:0] spd;

    // Reset state
    #2;
    chk("reset data", packet_data, 9'd0);
    chk("reset valid", 9'(packet_valid), 9'd0);
    chk("reset last", 9'(packet_last), 9'd0);
    chk("reset load", 9'(load), 9'd0);
    @(posedge clk_pixel);
    #1;
    reset_n = 1'b1;
    idle(1);

    // Null packet: all-zero codewords
    send_packet(24'h0, '0, 32);
    idle(1);

    // SPD-style packet
    spd[0] = 56'h4D_41_4E_45_44_4E_45;
    spd[1] = 56'h00_00_00_43_55_44_52;
    spd[2] = 56'h00_00_00_00_00_00_00;
    spd[3] = 56'h00_00_00_00_00_01_00;
    send_packet(24'h190183, spd, 32);
    idle(2);

    // Single-bit walks, back to back
    for (int i = 0; i < 24; i++) send_packet(24'(1) << i, '0, 32);
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 56; j++) begin
        s = '0;
        s[k] = 56'(1) << j;
        send_packet(24'h0, s, 32);
      end
    end
    idle(1);

    // Three random packets over 96 contiguous enable cycles
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 4; k++) s[k] = r56();
      send_packet(24'($urandom()), s, 32);
    end

    // Abort at n = 10 for 3 cycles, then a fresh packet
    for (int k = 0; k < 4; k++) s[k] = r56();
    send_packet(24'($urandom()), s, 10);
    idle(3);
    send_packet(24'hA5C3E1, s, 32);

    // Reset pulse at n = 17
    for (int k = 0; k < 4; k++) s[k] = r56();
    send_packet(24'h5A3C1E, s, 17);
    enable  = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst mid data", packet_data, 9'd0);
    chk("rst mid valid", 9'(packet_valid), 9'd0);
    chk("rst mid last", 9'(packet_last), 9'd0);
    @(posedge clk_pixel);
    #2;
    reset_n = 1'b1;
    chk("rst hold data", packet_data, 9'd0);
    for (int k = 0; k < 4; k++) s[k] = r56();
    send_packet(24'($urandom()), s, 32);
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_island_packet_serializer.md
DATA_ISLAND_PACKET_SERIALIZER -- requirements
Module: data_island_packet_serializer

Interface
REQ-001 The block SHALL have no parameters; all constants come from hdmi_packet_pkg.
REQ-002 clk_pixel  input  1  pixel clock; all state SHALL change on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 enable  input  1  high for the whole data-island period; low SHALL abort and idle the serializer.
REQ-005 header  input  24  packet header HB2:HB1:HB0, HB0 in bits [7:0].
REQ-006 sub  input  4x56  subpackets 0..3, byte PBk in bits [8k+7:8k].
REQ-007 packet_data  output  9  {sub3..0 odd bit, sub3..0 even bit, header bit}; bit0 = header, bits[4:1] = sub0..3 bit 2n, bits[8:5] = sub0..3 bit 2n+1.
REQ-008 packet_valid  output  1  packet_data carries a packet bit this cycle.
REQ-009 packet_last  output  1  high with bit index 31.
REQ-010 load  output  1  combinational; high when enable=1 and counter=0 (header/sub sampled on this edge).

Function
REQ-011 A 5-bit counter SHALL increment modulo 32 on each edge with enable=1 and SHALL clear to 0 on any edge with enable=0.
REQ-012 On an edge with load=1, header and sub SHALL be captured into shadow registers, and all five ECC registers SHALL start from 8'h00.
REQ-013 Each ECC update with data bit d SHALL be ecc <= (ecc >> 1) XOR (ecc[0] XOR d ? ECC_POLY : 0), with ECC_POLY = 8'h83.
REQ-014 Header, count n = 0..23: on the edge processing bit n, packet_data[0] <= header bit n, and the header ECC SHALL update once with that bit.
REQ-015 Header, n = 24..31: packet_data[0] <= header ECC bit (n-24); the ECC SHALL hold.
REQ-016 Subpacket k, n = 0..27: packet_data[1+k] <= sub bit 2n and packet_data[5+k] <= sub bit 2n+1; ECC k SHALL update with bit 2n, then bit 2n+1, in one cycle.
REQ-017 Subpacket k, n = 28..31: packet_data[1+k] <= ECC k bit 2(n-28) and packet_data[5+k] <= ECC k bit 2(n-28)+1.
REQ-018 At n = 0, bits SHALL come directly from the inputs, not the shadow registers; for n >= 1 they SHALL come from the shadow registers.
REQ-019 packet_data, packet_valid and packet_last SHALL be registered; bit n appears in the cycle after the edge processing n, giving a latency of 1 cycle from load.
REQ-020 packet_valid SHALL equal the enable value registered on the previous edge; packet_last SHALL be high only for n = 31.
REQ-021 Back-to-back packets: after n = 31 with enable still high, n wraps to 0, the next packet is loaded, and the output SHALL have no gap cycle.
REQ-022 Changes to header/sub while 1 <= n <= 31 SHALL NOT affect the packet in flight.
REQ-023 Abort: enable low mid-packet SHALL discard the partial packet; on the next cycle packet_valid = 0 and packet_data = 0, and the next enable high SHALL start a fresh packet at n = 0.

Reset
REQ-024 While reset_n = 0, the counter, shadow registers, ECC registers, packet_data, packet_valid and packet_last SHALL all be 0.
REQ-025 Reset assertion SHALL take effect asynchronously; deassertion SHALL be used only after synchronization elsewhere, and the first active edge SHALL behave as n = 0.

Structure
REQ-026 hdmi_packet_pkg SHALL hold: ECC_POLY = 8'h83, PACKET_BITS = 32, HEADER_DATA_BITS = 24, SUB_DATA_BITS = 56, SUBPACKETS = 4.
REQ-027 A single sub-module, bch_ecc_lfsr, SHALL contain one 8-bit ECC register with a 1- or 2-bit-per-cycle update.
REQ-028 bch_ecc_lfsr SHALL be instantiated 5 times: 1 for the header (width 1) and 4 for the subpackets (width 2).

Verification
REQ-029 Null packet: header = 0, sub = 0, enable held 32 cycles -> packet_data = 0 for all 32 bits, packet_last on the 32nd valid cycle.
REQ-030 SPD packet: header = 24'h190183 and SPD subpackets -> all 32x9 bits, including ECC, match a software BCH(32,24)/BCH(64,56) golden model.
REQ-031 Single-bit walk: header bit i = 1 for each i in 0..23 -> data bit appears at n = i and the ECC matches the model; the same walk SHALL be run for sub bit j in 0..55 of each subpacket.
REQ-032 Back-to-back: three different packets over 96 enable cycles -> no gap, packet_last at cycles 32/64/96, and changes to inputs mid-packet have no effect.
REQ-033 Abort: enable dropped at n = 10 for 3 cycles, then raised -> partial output stops, and the restarted packet is bit-exact from n = 0.
REQ-034 Reset mid-packet: reset_n pulsed low at n = 17 -> all outputs 0 immediately, and the next packet is correct.
